weight_shadow_bank: RTL and testbench

- Downstream of the weight/bias buffer; captures its 9-bit one-hot weight/bias beat stream into a shadow register bank.
- Shadow holds 8 kernel groups × 9 taps of `PE_CORE_NUM` weights, plus one bias word.
- On a swap handshake from the convolution controller, copies completed shadow sections into the active bank that drives the PE array.
- This lets the next layer's weights load while the PE array computes with the current ones.

---
 rtl/weight_shadow_bank_pkg.sv | 27 ++
 rtl/weight_tap_sequencer.sv | 127 ++++++++++++
 rtl/weight_shadow_bank.sv | 111 +++++++++++
 tb/tb_weight_shadow_bank.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_shadow_bank_pkg.sv
// Shared constants and types for the weight shadow bank.
//   GROUP_NUM kernel groups of TAP_NUM taps each, plus one bias word.
//   The beat qualifier is VALID_W bits wide and one-hot: bits 0..7 pick a
//   weight group, bit BIAS_SEL picks the bias.
package weight_shadow_bank_pkg;

    localparam int unsigned GROUP_NUM = 8;
    localparam int unsigned TAP_NUM   = 9;
    localparam int unsigned BIAS_SEL  = 8;
    localparam int unsigned VALID_W   = 9;
    localparam int unsigned TAP_TOTAL = GROUP_NUM * TAP_NUM;
    localparam int unsigned GRP_W     = 3;
    localparam int unsigned TAP_CNT_W = 4;
    localparam int unsigned IDX_W     = 7;

    // Shadow write address decoded from one weight beat.
    typedef struct packed {
        logic [GRP_W-1:0]     grp;
        logic [TAP_CNT_W-1:0] tap;
    } tap_addr_t;

    // Flat tap index: group-major, tap-minor.
    function automatic logic [IDX_W-1:0] tap_index(input tap_addr_t addr);
        return IDX_W'(addr.grp) * IDX_W'(TAP_NUM) + IDX_W'(addr.tap);
    endfunction

endpackage

// File: rtl/weight_tap_sequencer.sv
// Beat sequencer for the weight shadow bank.
//   Tracks the in-progress group (tap counter, current group), the mask of
//   completed groups, and decodes each beat into a shadow write strobe.
// Ports:
//   system_clk, rst_n          clock, async active-low reset
//   beat_valid                 one-hot beat qualifier from the buffer
//   bias_full, swap_exec       bias shadow flag and swap strobe from the top
//   weight_beat_c, busy_c      weight beat present / loader busy (comb)
//   wr_en_c, wr_addr_c         weight shadow write strobe and address (comb)
//   bias_wr_c                  bias shadow write strobe (comb)
//   weight_full                all groups present in shadow
//   protocol_err, overrun_err  sticky error flags
module weight_tap_sequencer
    import weight_shadow_bank_pkg::*;
(
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic [VALID_W-1:0] beat_valid,
    input  logic               bias_full,
    input  logic               swap_exec,
    output logic               weight_beat_c,
    output logic               busy_c,
    output logic               wr_en_c,
    output tap_addr_t          wr_addr_c,
    output logic               bias_wr_c,
    output logic               weight_full,
    output logic               protocol_err,
    output logic               overrun_err
);

    localparam logic [TAP_CNT_W-1:0] LAST_TAP = TAP_CNT_W'(TAP_NUM - 1);

    logic [TAP_CNT_W-1:0] tap_cnt,  tap_cnt_nxt;
    logic [GRP_W-1:0]     cur_grp,  cur_grp_nxt;
    logic [GROUP_NUM-1:0] grp_mask, grp_mask_nxt;
    logic                 protocol_err_nxt, overrun_err_nxt;
    logic [VALID_W-1:0]   valid_m1;
    logic                 onehot_c;
    logic                 bias_beat_c;
    logic [GRP_W-1:0]     beat_grp_c;

    // One-hot check: clearing the lowest set bit must leave nothing.
    assign valid_m1      = beat_valid - VALID_W'(1);
    assign onehot_c      = (beat_valid != '0) && ((beat_valid & valid_m1) == '0);
    assign weight_beat_c = onehot_c && !beat_valid[BIAS_SEL];
    assign bias_beat_c   = onehot_c && beat_valid[BIAS_SEL];

    // Busy while a group is partly loaded or the group set is partial.
    assign busy_c = (tap_cnt != '0) || ((grp_mask != '0) && (grp_mask != '1));

    // Encode the selected group.
    always_comb begin
        beat_grp_c = '0;
        for (int k = 0; k < int'(GROUP_NUM); k++) begin
            if (beat_valid[k]) begin
                beat_grp_c = GRP_W'(k);
            end
        end
    end

    // Next-state and write-strobe decode.
    always_comb begin
        tap_cnt_nxt      = tap_cnt;
        cur_grp_nxt      = cur_grp;
        grp_mask_nxt     = grp_mask;
        protocol_err_nxt = protocol_err;
        overrun_err_nxt  = overrun_err;
        wr_en_c          = 1'b0;
        wr_addr_c.grp    = beat_grp_c;
        wr_addr_c.tap    = tap_cnt;
        bias_wr_c        = 1'b0;

        if ((beat_valid != '0) && !onehot_c) begin
            protocol_err_nxt = 1'b1;
        end else if (weight_beat_c) begin
            if (weight_full) begin
                overrun_err_nxt = 1'b1;
            end else begin
                wr_en_c     = 1'b1;
                cur_grp_nxt = beat_grp_c;
                if ((tap_cnt != '0) && (beat_grp_c != cur_grp)) begin
                    // Abandon the partial group; this beat restarts at tap 0.
                    protocol_err_nxt = 1'b1;
                    wr_addr_c.tap    = '0;
                    tap_cnt_nxt      = TAP_CNT_W'(1);
                end else if (tap_cnt == LAST_TAP) begin
                    tap_cnt_nxt              = '0;
                    grp_mask_nxt[beat_grp_c] = 1'b1;
                end else begin
                    tap_cnt_nxt = tap_cnt + TAP_CNT_W'(1);
                end
            end
        end else if (bias_beat_c) begin
            // A swap frees the bias shadow in the same cycle.
            if (bias_full && !swap_exec) begin
                overrun_err_nxt = 1'b1;
            end else begin
                bias_wr_c = 1'b1;
            end
        end

        // Swap never coincides with a weight beat, so no write conflict.
        if (swap_exec && weight_full) begin
            grp_mask_nxt = '0;
        end
    end

    // State registers.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt      <= '0;
            cur_grp      <= '0;
            grp_mask     <= '0;
            weight_full  <= 1'b0;
            protocol_err <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            tap_cnt      <= tap_cnt_nxt;
            cur_grp      <= cur_grp_nxt;
            grp_mask     <= grp_mask_nxt;
            weight_full  <= (grp_mask_nxt == '1);
            protocol_err <= protocol_err_nxt;
            overrun_err  <= overrun_err_nxt;
        end
    end

endmodule

// File: rtl/weight_shadow_bank.sv
// Weight shadow bank: captures the one-hot weight/bias beat stream into a
// shadow bank and copies completed sections into the active bank on a swap
// handshake, so the next layer loads while the PE array computes.
// Ports:
//   system_clk, rst_n                   clock, async active-low reset
//   weight_bias_data, weight_bias_valid beat data and one-hot qualifier
//   swap_req / swap_ack                 level request / one-cycle ack pulse
//   shadow_weight_full, shadow_bias_full shadow completion flags
//   active_weight, active_bias          active bank driving the PE array
//   protocol_err, overrun_err           sticky error flags
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif
`ifndef PE_CORE_NUM
`define PE_CORE_NUM 4
`endif

module weight_shadow_bank
    import weight_shadow_bank_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH      = `WEIGHT_WIDTH,
    parameter int unsigned PE_CORE_NUM       = `PE_CORE_NUM,
    parameter int unsigned WEIGHT_DATA_WIDTH = PE_CORE_NUM * WEIGHT_WIDTH
) (
    input  logic                                   system_clk,
    input  logic                                   rst_n,
    input  logic [WEIGHT_DATA_WIDTH-1:0]           weight_bias_data,
    input  logic [8:0]                             weight_bias_valid,
    input  logic                                   swap_req,
    output logic                                   swap_ack,
    output logic                                   shadow_weight_full,
    output logic                                   shadow_bias_full,
    output logic [72*WEIGHT_DATA_WIDTH-1:0]        active_weight,
    output logic [WEIGHT_DATA_WIDTH-1:0]           active_bias,
    output logic                                   protocol_err,
    output logic                                   overrun_err
);

    localparam int unsigned WDW = WEIGHT_DATA_WIDTH;

    logic [WDW-1:0]   shadow_w [TAP_TOTAL];
    logic [WDW-1:0]   shadow_bias;
    logic             weight_beat_c;
    logic             busy_c;
    logic             wr_en_c;
    tap_addr_t        wr_addr_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             bias_wr_c;
    logic             swap_exec_c;

    weight_tap_sequencer u_seq (
        .system_clk    (system_clk),
        .rst_n         (rst_n),
        .beat_valid    (weight_bias_valid),
        .bias_full     (shadow_bias_full),
        .swap_exec     (swap_exec_c),
        .weight_beat_c (weight_beat_c),
        .busy_c        (busy_c),
        .wr_en_c       (wr_en_c),
        .wr_addr_c     (wr_addr_c),
        .bias_wr_c     (bias_wr_c),
        .weight_full   (shadow_weight_full),
        .protocol_err  (protocol_err),
        .overrun_err   (overrun_err)
    );

    assign wr_idx_c = tap_index(wr_addr_c);

    // Swap fires when idle and no weight beat; the ack cycle is skipped so a
    // still-held request is only re-serviced once seen again afterwards.
    assign swap_exec_c = swap_req && !busy_c && !weight_beat_c && !swap_ack;

    // Shadow capture, swap copy and ack.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAP_TOTAL); i++) begin
                shadow_w[i] <= '0;
            end
            shadow_bias      <= '0;
            shadow_bias_full <= 1'b0;
            active_weight    <= '0;
            active_bias      <= '0;
            swap_ack         <= 1'b0;
        end else begin
            swap_ack <= swap_exec_c;

            if (wr_en_c) begin
                shadow_w[wr_idx_c] <= weight_bias_data;
            end

            if (swap_exec_c && shadow_weight_full) begin
                for (int i = 0; i < int'(TAP_TOTAL); i++) begin
                    active_weight[i*WDW +: WDW] <= shadow_w[i];
                end
            end

            // Old bias is copied before a same-cycle beat refills the shadow.
            if (swap_exec_c && shadow_bias_full) begin
                active_bias <= shadow_bias;
            end

            if (bias_wr_c) begin
                shadow_bias      <= weight_bias_data;
                shadow_bias_full <= 1'b1;
            end else if (swap_exec_c) begin
                shadow_bias_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_shadow_bank.sv
// Scoreboard bench for weight_shadow_bank (PE_CORE_NUM=4, WEIGHT_WIDTH=8).
module tb_weight_shadow_bank;

    localparam int unsigned WDW = 32;
    localparam int unsigned NT  = 72;

    typedef struct packed {
        logic [NT*WDW-1:0] w;
        logic [WDW-1:0]    b;
    } exp_t;

    logic              system_clk = 1'b0;
    logic              rst_n;
    logic [WDW-1:0]    weight_bias_data;
    logic [8:0]        weight_bias_valid;
    logic              swap_req;
    logic              swap_ack;
    logic              shadow_weight_full;
    logic              shadow_bias_full;
    logic [NT*WDW-1:0] active_weight;
    logic [WDW-1:0]    active_bias;
    logic              protocol_err;
    logic              overrun_err;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    // Behavioural reference: shadow/active banks as plain arrays.
    logic [WDW-1:0] m_sh  [NT];
    logic [WDW-1:0] m_act [NT];
    logic [WDW-1:0] m_bias, m_act_b;
    logic [7:0]     m_mask;
    int             m_tap, m_grp;
    bit             m_bfull, m_perr, m_oerr;

    always #5 system_clk = ~system_clk;

    weight_shadow_bank #(
        .WEIGHT_WIDTH (8),
        .PE_CORE_NUM  (4)
    ) dut (
        .system_clk         (system_clk),
        .rst_n              (rst_n),
        .weight_bias_data   (weight_bias_data),
        .weight_bias_valid  (weight_bias_valid),
        .swap_req           (swap_req),
        .swap_ack           (swap_ack),
        .shadow_weight_full (shadow_weight_full),
        .shadow_bias_full   (shadow_bias_full),
        .active_weight      (active_weight),
        .active_bias        (active_bias),
        .protocol_err       (protocol_err),
        .overrun_err        (overrun_err)
    );

    function automatic void model_reset();
        for (int i = 0; i < int'(NT); i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_bias = '0; m_act_b = '0; m_mask = '0;
        m_tap = 0; m_grp = 0;
        m_bfull = 0; m_perr = 0; m_oerr = 0;
    endfunction

    function automatic void model_beat(input logic [8:0] v, input logic [WDW-1:0] d);
        int k;
        if (v == '0) return;
        if ($countones(v) != 1) begin
            m_perr = 1;
            return;
        end
        if (v[8]) begin
            if (m_bfull) m_oerr = 1;
            else begin
                m_bias  = d;
                m_bfull = 1;
            end
            return;
        end
        if (m_mask == 8'hFF) begin
            m_oerr = 1;
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (v[i]) k = i;
        if (m_tap != 0 && k != m_grp) begin
            m_perr = 1;
            m_tap  = 0;
        end
        m_sh[k*9 + m_tap] = d;
        m_grp = k;
        m_tap++;
        if (m_tap == 9) begin
            m_tap     = 0;
            m_mask[k] = 1'b1;
        end
    endfunction

    // Apply a swap to the model and queue the active bank it should produce.
    function automatic void model_swap();
        exp_t e;
        if (m_mask == 8'hFF) begin
            for (int i = 0; i < int'(NT); i++) m_act[i] = m_sh[i];
            m_mask = '0;
        end
        if (m_bfull) begin
            m_act_b = m_bias;
            m_bfull = 0;
        end
        for (int i = 0; i < int'(NT); i++) e.w[i*WDW +: WDW] = m_act[i];
        e.b = m_act_b;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [WDW-1:0] act_slice(input int g, input int t);
        return active_weight[(g*9 + t)*WDW +: WDW];
    endfunction

    task automatic idle();
        @(posedge system_clk);
        #1;
    endtask

    task automatic send(input logic [8:0] v, input logic [WDW-1:0] d);
        weight_bias_valid = v;
        weight_bias_data  = d;
        idle();
        weight_bias_valid = '0;
        model_beat(v, d);
    endtask

    task automatic load_group(input int g, input logic [WDW-1:0] base);
        logic [8:0] v;
        v = 9'd1 << g;
        for (int t = 0; t < 9; t++) send(v, base + WDW'(t));
    endtask

    // 72 weight beats (ordered or shuffled groups) with an optional bias beat.
    task automatic full_load(input bit rnd, input logic [WDW-1:0] tag,
                             input bit add_bias, input logic [WDW-1:0] bias);
        int ord[8];
        int bias_at;
        int idx;
        logic [8:0] v;
        logic [WDW-1:0] d;
        for (int i = 0; i < 8; i++) ord[i] = i;
        if (rnd) begin
            for (int i = 7; i > 0; i--) begin
                int j, tmp;
                j = int'($urandom_range(i, 0));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
        end
        bias_at = !add_bias ? -1 : (rnd ? int'($urandom_range(71, 0)) : 72);
        idx = 0;
        for (int gi = 0; gi < 8; gi++) begin
            v = 9'd1 << ord[gi];
            for (int t = 0; t < 9; t++) begin
                if (idx == bias_at) send(9'h100, bias);
                d = rnd ? WDW'($urandom) : tag + WDW'(ord[gi]*256 + t);
                send(v, d);
                if (rnd) repeat ($urandom_range(2, 0)) idle();
                idx++;
            end
        end
        if (bias_at == 72) send(9'h100, bias);
    endtask

    // Hold swap_req through the ack cycle to confirm it is not re-serviced.
    task automatic do_swap(input bit with_bias, input logic [WDW-1:0] d);
        int n;
        model_swap();
        if (with_bias) model_beat(9'h100, d);
        swap_req = 1'b1;
        if (with_bias) begin
            weight_bias_valid = 9'h100;
            weight_bias_data  = d;
        end
        n = 0;
        do begin
            idle();
            weight_bias_valid = '0;
            n++;
        end while (!swap_ack && n < 40);
        check("swap_ack_seen", 32'(swap_ack), 32'd1);
        idle();
        swap_req = 1'b0;
        check("ack_pulse", 32'(swap_ack), 32'd0);
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   32'(swap_ack), 32'd0);
        check({tag, "_wfull"}, 32'(shadow_weight_full), 32'd0);
        check({tag, "_bfull"}, 32'(shadow_bias_full), 32'd0);
        check({tag, "_perr"},  32'(protocol_err), 32'd0);
        check({tag, "_oerr"},  32'(overrun_err), 32'd0);
        check({tag, "_bias"},  active_bias, 32'd0);
        check({tag, "_weight_nonzero"}, 32'(|active_weight), 32'd0);
    endtask

    // Test 1 body, reused after the reset test.
    task automatic test_full_swap(input string tag);
        full_load(1'b0, 32'h0, 1'b1, 32'hB1A5);
        check({tag, "_wfull"}, 32'(shadow_weight_full), 32'd1);
        check({tag, "_bfull"}, 32'(shadow_bias_full), 32'd1);
        do_swap(1'b0, '0);
        check({tag, "_slice34"}, act_slice(3, 4), 32'h304);
        check({tag, "_slice70"}, act_slice(7, 0), 32'h700);
        check({tag, "_bias"}, active_bias, 32'hB1A5);
        check({tag, "_wfull_after"}, 32'(shadow_weight_full), 32'd0);
        check({tag, "_bfull_after"}, 32'(shadow_bias_full), 32'd0);
    endtask

    // Monitor: every ack must match the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        int   bad_tap;
        forever begin
            @(negedge system_clk);
            if (rst_n === 1'b1 && swap_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack got=ack exp=no_ack at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    bad_tap = -1;
                    for (int i = int'(NT) - 1; i >= 0; i--) begin
                        if (active_weight[i*WDW +: WDW] !== e.w[i*WDW +: WDW]) bad_tap = i;
                    end
                    n_cmp++;
                    if (bad_tap >= 0) begin
                        n_bad++;
                        $display("FAIL swap_weights tap=%0d got=%h exp=%h", bad_tap,
                                 active_weight[bad_tap*WDW +: WDW], e.w[bad_tap*WDW +: WDW]);
                    end
                    check("swap_bias", active_bias, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n             = 1'b0;
        weight_bias_data  = '0;
        weight_bias_valid = '0;
        swap_req          = 1'b0;
        model_reset();
        repeat (3) @(posedge system_clk);
        #1;
        check_all_zero("reset");
        @(negedge system_clk);
        rst_n = 1'b1;
        idle();

        // 1: full load then swap
        test_full_swap("t1");

        // 2: bias-only refresh
        send(9'h100, 32'h22);
        do_swap(1'b0, '0);
        check("t2_bias", active_bias, 32'h22);
        check("t2_slice34", act_slice(3, 4), 32'h304);

        // 2b: bias beat in the swap cycle while the bias shadow is full
        send(9'h100, 32'h33);
        do_swap(1'b1, 32'h44);
        check("t2b_bias_old", active_bias, 32'h33);
        check("t2b_bfull", 32'(shadow_bias_full), 32'd1);
        check("t2b_no_overrun", 32'(overrun_err), 32'd0);
        do_swap(1'b0, '0);
        check("t2b_bias_new", active_bias, 32'h44);

        // 3: swap requested while busy
        for (int t = 0; t < 5; t++) send(9'h001, 32'h3000_0000 + WDW'(t));
        swap_req = 1'b1;
        for (int t = 5; t < 9; t++) send(9'h001, 32'h3000_0000 + WDW'(t));
        for (int g = 1; g < 8; g++) load_group(g, 32'h3000_0000 + WDW'(g*256));
        model_swap();
        check("t3_wfull_rise", 32'(shadow_weight_full), 32'd1);
        check("t3_no_ack_yet", 32'(swap_ack), 32'd0);
        idle();
        check("t3_ack_next", 32'(swap_ack), 32'd1);
        idle();
        swap_req = 1'b0;
        idle();
        check("t3_slice25", act_slice(2, 5), 32'h3000_0205);
        check("t3_bias_kept", active_bias, 32'h44);

        // 4: protocol errors
        check("t4_perr_pre", 32'(protocol_err), 32'd0);
        send(9'h003, 32'hEEEE_EEEE);
        check("t4_perr_onehot", 32'(protocol_err), 32'd1);
        check("t4_no_beat", 32'(shadow_weight_full), 32'd0);
        for (int t = 0; t < 4; t++) send(9'h001, 32'h4000_0000 + WDW'(t));
        send(9'h002, 32'hDEAD_0001);
        for (int t = 1; t < 9; t++) send(9'h002, 32'h4000_0100 + WDW'(t));
        for (int g = 2; g < 8; g++) load_group(g, 32'h4000_0000 + WDW'(g*256));
        load_group(0, 32'h5000_0000);
        check("t4_wfull", 32'(shadow_weight_full), 32'd1);
        do_swap(1'b0, '0);
        check("t4_grp1_tap0", act_slice(1, 0), 32'hDEAD_0001);
        check("t4_grp1_tap1", act_slice(1, 1), 32'h4000_0101);
        check("t4_grp0_tap3", act_slice(0, 3), 32'h5000_0003);
        check("t4_perr_sticky", 32'(protocol_err), 32'd1);

        // 5: overrun
        check("t5_oerr_pre", 32'(overrun_err), 32'd0);
        full_load(1'b1, '0, 1'b1, WDW'($urandom));
        send(9'h001, 32'hBAD0_0001);
        check("t5_oerr", 32'(overrun_err), 32'd1);
        send(9'h100, 32'hBAD0_0002);
        check("t5_wfull_kept", 32'(shadow_weight_full), 32'd1);
        do_swap(1'b0, '0);

        // Random loads with shuffled group order, gaps and bias placement.
        for (int it = 0; it < 6; it++) begin
            full_load(1'b1, '0, ($urandom_range(3, 0) != 0), WDW'($urandom));
            check("rnd_wfull", 32'(shadow_weight_full), 32'd1);
            check("rnd_bfull", 32'(shadow_bias_full), 32'(m_bfull));
            do_swap(1'b0, '0);
        end
        check("rnd_perr", 32'(protocol_err), 32'(m_perr));
        check("rnd_oerr", 32'(overrun_err), 32'(m_oerr));

        // 6: reset mid-load and mid-request
        for (int t = 0; t < 20; t++) send(9'd1 << (t / 9), 32'h6000_0000 + WDW'(t));
        swap_req = 1'b1;
        for (int t = 20; t < 23; t++) send(9'h004, 32'h6000_0000 + WDW'(t));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        swap_req = 1'b0;
        repeat (2) @(posedge system_clk);
        @(negedge system_clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        test_full_swap("t6");
        check("t6_perr", 32'(protocol_err), 32'd0);

        repeat (3) idle();
        check("pending_expect", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
